md_unit: RTL and testbench

- Multiply/divide unit in the EX stage of the pipelined MIPS core, fed directly by the register-file read ports (RData1/RData2, forwarded).
- Executes mult, multu, div, divu with fixed multi-cycle latency and holds the HI/LO registers.
- Also services mthi/mtlo writes and mfhi/mflo reads.
- The busy output drives the hazard unit's stall logic.

---
 rtl/md_unit_pkg.sv | 22 ++
 rtl/md_calc.sv | 59 +++++
 rtl/md_unit.sv | 108 ++++++++++
 tb/tb_md_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared op codes, FSM state encoding and helpers for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which reads
    // correctly as 2^31 when the result is treated as unsigned.
    function automatic logic [31:0] md_abs(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: op, a, b -> {hi_res, lo_res} and div_by_zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever inputs are.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed division is done on magnitudes and the signs patched afterwards,
    // which also gives 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
    always_comb begin
        sgn         = (op == MD_DIV);
        mag_a       = sgn ? md_abs(a) : a;
        mag_b       = sgn ? md_abs(b) : b;
        div_by_zero = op[1] && (b == 32'd0);
        // Substitute divisor 1 for zero so the divider never sees x/0;
        // the flag suppresses the write-back anyway.
        div_b       = (b == 32'd0) ? 32'd1 : mag_b;
        quo_u       = mag_a / div_b;
        rem_u       = mag_a % div_b;
        quo         = (sgn && (a[31] ^ b[31])) ? (32'd0 - quo_u) : quo_u;
        rem         = (sgn && a[31]) ? (32'd0 - rem_u) : rem_u;
    end

    // Select the 64-bit result for the requested op.
    always_comb begin
        hi_res = rem;
        lo_res = quo;
        case (op)
            MD_MULT:  {hi_res, lo_res} = prod_s;
            MD_MULTU: {hi_res, lo_res} = prod_u;
            default: begin
                hi_res = rem;
                lo_res = quo;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// MIPS EX-stage multiply/divide unit holding HI/LO; result lands N cycles after start.
// Latency: MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu (busy high exactly N cycles).
// Backpressure: busy stalls issue; start/mthi/mtlo while busy are ignored.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

    md_state_t      state;
    md_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]    calc_hi;
    logic [31:0]    calc_lo;
    logic           calc_dbz;
    logic [31:0]    res_hi;
    logic [31:0]    res_lo;
    logic           res_dbz;
    logic           accept;
    logic           done;
    logic           mt_ok;

    md_calc u_calc (
        .op          (op),
        .a           (A),
        .b           (B),
        .hi_res      (calc_hi),
        .lo_res      (calc_lo),
        .div_by_zero (calc_dbz)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave IDLE on start, return when the count expires.
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start)                state_nxt = MD_BUSY;
            MD_BUSY: if (cnt == CNT_W'(1))     state_nxt = MD_IDLE;
            default:                           state_nxt = MD_IDLE;
        endcase
    end

    // FSM outputs and write qualifiers.
    always_comb begin
        busy   = (state == MD_BUSY);
        accept = (state == MD_IDLE) && start;
        done   = (state == MD_BUSY) && (cnt == CNT_W'(1));
        mt_ok  = (state == MD_IDLE) && !start;
    end

    // Capture the result at start (operands need not be held) and run the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            res_hi  <= '0;
            res_lo  <= '0;
            res_dbz <= 1'b0;
        end else if (accept) begin
            cnt     <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            res_hi  <= calc_hi;
            res_lo  <= calc_lo;
            res_dbz <= calc_dbz;
        end else if (busy) begin
            cnt     <= cnt - CNT_W'(1);
        end
    end

    // HI/LO: completion write-back, else mthi/mtlo when idle and no start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= '0;
            LO <= '0;
        end else if (done) begin
            if (!res_dbz) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end else if (mt_ok) begin
            if (hi_we) HI <= A;
            if (lo_we) LO <= A;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops vs a 64-bit arithmetic model.
// Latency: checks busy every cycle of each op and HI/LO on the completion edge.
// Backpressure: injects start/mthi/mtlo while busy and expects them to be ignored.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic [1:0]  op;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int passed;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .start (start),
        .op    (op),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit integer arithmetic on the architectural definitions.
    function automatic void ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output bit dz);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        h  = 32'd0;
        l  = 32'd0;
        case (o)
            2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            2'b10: begin
                if (b == 32'd0) dz = 1'b1;
                else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) dz = 1'b1;
                else begin uq = ua / ub; ur = ua % ub; l = uq[31:0]; h = ur[31:0]; end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        A     = $urandom;
        B     = $urandom;
        op    = 2'($urandom_range(0, 3));
    endtask

    // Issue one op; optionally assert mthi/mtlo alongside start, and/or
    // inject a colliding start + mthi/mtlo mid-flight. Checks every cycle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit collide, input bit mt_same);
        logic [31:0] nh, nl;
        bit          dz;
        int          n;
        ref_calc(o, a, b, nh, nl, dz);
        n     = o[1] ? DIV_N : MULT_N;
        A     = a;
        B     = b;
        op    = o;
        start = 1'b1;
        hi_we = mt_same;
        lo_we = mt_same;
        tick();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (busy !== 1'b1) $display("FAIL %s busy cyc%0d: got %b want 1", name, i, busy);
            else passed++;
            checks++;
            if (HI !== exp_hi || LO !== exp_lo)
                $display("FAIL %s early_hilo cyc%0d: got %h_%h want %h_%h", name, i, HI, LO, exp_hi, exp_lo);
            else passed++;
            idle_inputs();
            if (collide && i == 2) begin
                start = 1'b1;
                hi_we = 1'b1;
                lo_we = 1'b1;
            end
            tick();
        end
        idle_inputs();
        if (!dz) begin
            exp_hi = nh;
            exp_lo = nl;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_drop: got %b want 0", name, busy);
        else passed++;
        checks++;
        if (HI !== exp_hi || LO !== exp_lo)
            $display("FAIL %s result: got %h_%h want %h_%h", name, HI, LO, exp_hi, exp_lo);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        checks++;
        if (HI !== 32'd0) $display("FAIL reset_hi: got %h want 0", HI); else passed++;
        checks++;
        if (LO !== 32'd0) $display("FAIL reset_lo: got %h want 0", LO); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        reset = 1'b1;
        tick();
        A     = 32'd5;
        hi_we = 1'b1;
        tick();
        idle_inputs();
        exp_hi = 32'd5;
        checks++;
        if (HI !== 32'd5 || LO !== 32'd0) $display("FAIL mthi_after_reset: got %h_%h want 5_0", HI, LO);
        else passed++;
    endtask

    task automatic test_mt_writes();
        logic [31:0] v;
        v = $urandom; A = v; lo_we = 1'b1; tick(); idle_inputs(); exp_lo = v;
        checks++;
        if (LO !== exp_lo || HI !== exp_hi) $display("FAIL mtlo: got %h_%h want %h_%h", HI, LO, exp_hi, exp_lo);
        else passed++;
        v = $urandom; A = v; hi_we = 1'b1; lo_we = 1'b1; tick(); idle_inputs(); exp_hi = v; exp_lo = v;
        checks++;
        if (LO !== exp_lo || HI !== exp_hi) $display("FAIL mthi_mtlo_both: got %h_%h want %h_%h", HI, LO, exp_hi, exp_lo);
        else passed++;
    endtask

    task automatic test_directed();
        run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", HI, LO);
        else passed++;
        run_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 0, 0);
        checks++;
        if (HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) $display("FAIL multu_const: got %h_%h want 00000002_fffffffa", HI, LO);
        else passed++;
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) $display("FAIL div_neg_const: got %h_%h want ffffffff_fffffffd", HI, LO);
        else passed++;
        run_op("divu", 2'b11, 32'd7, 32'd2, 0, 0);
        checks++;
        if (HI !== 32'd1 || LO !== 32'd3) $display("FAIL divu_const: got %h_%h want 00000001_00000003", HI, LO);
        else passed++;
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        checks++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) $display("FAIL div_ovf_const: got %h_%h want 00000000_80000000", HI, LO);
        else passed++;
    endtask

    task automatic test_collisions();
        run_op("collide_div", 2'b10, 32'd1000, 32'hFFFF_FFF3, 1, 0);
        run_op("collide_mult", 2'b00, $urandom, $urandom, 1, 0);
        run_op("start_beats_mt", 2'b01, $urandom, $urandom, 0, 1);
        A = 32'h1234_5678; hi_we = 1'b1; lo_we = 1'b1; tick(); idle_inputs();
        exp_hi = 32'h1234_5678; exp_lo = 32'h1234_5678;
        run_op("divu_by_zero", 2'b11, 32'd99, 32'd0, 0, 0);
        run_op("div_by_zero", 2'b10, 32'hFFFF_0000, 32'd0, 1, 0);
        checks++;
        if (HI !== 32'h1234_5678 || LO !== 32'h1234_5678) $display("FAIL dbz_keep: got %h_%h want 12345678_12345678", HI, LO);
        else passed++;
    endtask

    task automatic test_back_to_back();
        // run_op leaves start low only in the completion cycle's inputs; issue immediately again.
        for (int i = 0; i < 4; i++)
            run_op("b2b", 2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 50), 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 17) ^ ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd0);
            run_op("rand", 2'($urandom_range(0, 3)), a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_reset_mid();
        A = 32'd100; B = 32'd7; op = 2'b10; start = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        #2 reset = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        checks++;
        if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0) $display("FAIL midreset_hilo: got %h_%h want 0_0", HI, LO);
        else passed++;
        tick();
        reset = 1'b1;
        for (int i = 0; i < DIV_N + 2; i++) tick();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            $display("FAIL midreset_no_late: got busy=%b %h_%h want 0 0_0", busy, HI, LO);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset  = 1'b0;
        start  = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        A      = 32'd0;
        B      = 32'd0;
        op     = 2'b00;
        test_reset();
        test_mt_writes();
        test_directed();
        test_collisions();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
